// File: rtl/multi_lane_min2_matcher.sv
// Nearest/second-nearest tracker: per-beat lane reduction (S1), then a sweep accumulator feeding the output register.
// Latency: S1 loads on accept and the result register on the following edge; out_valid & ~out_ready freezes both stages and drops in_ready.
module multi_lane_min2_matcher #(
  parameter int LANES     = 4,
  parameter int DW        = 15,
  parameter int CW        = 19,
  parameter int RW        = 4,
  parameter int RATIO_NUM = 4,
  parameter int RATIO_DEN = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [LANES-1:0]    in_mask,
  input  logic [LANES*DW-1:0] in_dist,
  input  logic [LANES*CW-1:0] in_coord,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_coord,
  output logic [DW-1:0]       out_min,
  output logic [DW-1:0]       out_min2,
  output logic                out_pass,
  output logic                out_none
);

  localparam int PW = DW + RW;
  localparam logic [DW-1:0] ONES = '1;

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] mn;
    logic [DW-1:0] mn2;
    logic [CW-1:0] crd;
  } trip_t;

  localparam trip_t IDLE = '{vld: 1'b0, mn: ONES, mn2: ONES, crd: '0};

  // a is the lower lane / older accumulator: it keeps the win on ties and a masked side never wins
  function automatic trip_t merge2(input trip_t a, input trip_t b);
    trip_t r;
    r.vld = a.vld | b.vld;
    if (b.vld && (!a.vld || (b.mn < a.mn))) begin
      r.mn  = b.mn;
      r.crd = b.crd;
      r.mn2 = (a.mn < b.mn2) ? a.mn : b.mn2;
    end else begin
      r.mn  = a.mn;
      r.crd = a.crd;
      r.mn2 = (b.mn < a.mn2) ? b.mn : a.mn2;
    end
    return r;
  endfunction

  function automatic trip_t reduce_lanes(input logic [LANES-1:0]    m,
                                         input logic [LANES*DW-1:0] d,
                                         input logic [LANES*CW-1:0] c);
    trip_t node [LANES];
    for (int i = 0; i < LANES; i++) begin
      node[i].vld = m[i];
      node[i].mn  = m[i] ? d[i*DW +: DW] : ONES;
      node[i].mn2 = ONES;
      node[i].crd = m[i] ? c[i*CW +: CW] : '0;
    end
    for (int s = 1; s < LANES; s = s * 2) begin
      for (int i = 0; i < LANES; i = i + 2 * s) begin
        node[i] = merge2(node[i], node[i+s]);
      end
    end
    return node[0];
  endfunction

  logic          stall;
  logic          s1_vld, s1_first, s1_last;
  trip_t         s1_grp, acc, merged, grp_c;
  logic [PW-1:0] prod_min, prod_min2;
  logic          pass_c;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    grp_c  = reduce_lanes(in_mask, in_dist, in_coord);
    merged = s1_first ? s1_grp : merge2(acc, s1_grp);
  end

  assign prod_min  = PW'(merged.mn)  * PW'(RATIO_DEN);
  assign prod_min2 = PW'(merged.mn2) * PW'(RATIO_NUM);
  assign pass_c    = merged.vld & (prod_min < prod_min2);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_grp   <= IDLE;
    end else if (!stall) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_grp   <= grp_c;
      end
    end
  end

  // The accumulator re-arms in the same cycle a sweep result is loaded
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc <= IDLE;
    end else if (!stall && s1_vld) begin
      acc <= s1_last ? IDLE : merged;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      out_coord <= '0;
      out_min   <= '0;
      out_min2  <= '0;
      out_pass  <= 1'b0;
      out_none  <= 1'b1;
    end else if (!stall) begin
      out_valid <= s1_vld & s1_last;
      if (s1_vld && s1_last) begin
        out_none  <= ~merged.vld;
        out_coord <= merged.vld ? merged.crd : '0;
        out_min   <= merged.vld ? merged.mn  : ONES;
        out_min2  <= merged.vld ? merged.mn2 : ONES;
        out_pass  <= pass_c;
      end
    end
  end

endmodule

// File: tb/tb_multi_lane_min2_matcher.sv
// Directed bench for multi_lane_min2_matcher: drives on falling edges, samples outputs on falling edges.
module tb_multi_lane_min2_matcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_first, in_last;
  logic [3:0]  in_mask;
  logic [59:0] in_dist;
  logic [75:0] in_coord;
  logic        out_valid, out_ready, out_pass, out_none;
  logic [18:0] out_coord;
  logic [14:0] out_min, out_min2;

  int checks = 0;
  int errors = 0;

  logic [50:0] res;
  logic [50:0] exp_v;
  int          cyc;

  assign res = {out_none, out_pass, out_coord, out_min2, out_min};

  multi_lane_min2_matcher dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_mask(in_mask), .in_dist(in_dist), .in_coord(in_coord),
    .out_valid(out_valid), .out_ready(out_ready), .out_coord(out_coord),
    .out_min(out_min), .out_min2(out_min2), .out_pass(out_pass), .out_none(out_none)
  );

  always #5 clk = ~clk;

  function automatic logic [59:0] d4(input int a, input int b, input int c, input int e);
    return {e[14:0], c[14:0], b[14:0], a[14:0]};
  endfunction

  function automatic logic [75:0] crd4(input int base);
    return {19'(base + 3), 19'(base + 2), 19'(base + 1), 19'(base)};
  endfunction

  function automatic logic [50:0] mk(input bit none, input bit pass, input int coord,
                                     input int mn2, input int mn);
    return {none, pass, 19'(coord), 15'(mn2), 15'(mn)};
  endfunction

  // Presents one beat at a falling edge and returns at the falling edge after it is accepted
  task automatic send(input bit f, input bit l, input logic [3:0] m,
                      input logic [59:0] d, input logic [75:0] c);
    int n;
    in_first = f; in_last = l; in_mask = m; in_dist = d; in_coord = c;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!out_valid) c = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_mask = '0; in_dist = '0; in_coord = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, res} !== {1'b1, 1'b0, mk(1, 0, 0, 0, 0)}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b res=%h, want rdy=1 vld=0 res=%h",
               in_ready, out_valid, res, mk(1, 0, 0, 0, 0));
    end
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_first();
    send(0, 1, 4'b1111, d4(30, 10, 20, 40), crd4(50));
    wait_out(cyc);
    exp_v = mk(0, 1, 51, 20, 10);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL no_first: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_tie_latency();
    send(1, 1, 4'b1111, d4(100, 40, 70, 40), crd4(100));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tie_early_valid: got out_valid=%0b, want 0", out_valid);
    end
    wait_out(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL tie_latency: got %0d extra cycles, want 1", cyc);
    end
    exp_v = mk(0, 0, 101, 40, 40);
    checks++;
    if (res !== exp_v) begin
      errors++;
      $display("FAIL tie_result: got res=%h, want res=%h", res, exp_v);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL tie_consumed: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_sweep();
    send(1, 0, 4'b1111, d4(90, 80, 300, 200), crd4(200));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_mid_valid: got out_valid=%0b, want 0", out_valid);
    end
    send(0, 1, 4'b1111, d4(85, 95, 60, 500), crd4(300));
    wait_out(cyc);
    exp_v = mk(0, 1, 302, 80, 60);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL sweep_result: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
    send(1, 0, 4'b1111, d4(50, 60, 70, 80), crd4(1000));
    send(0, 1, 4'b1111, d4(90, 50, 95, 99), crd4(1100));
    wait_out(cyc);
    exp_v = mk(0, 0, 1000, 50, 50);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL sweep_acc_tie: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_mask();
    send(1, 1, 4'b0010, d4(1, 50, 2, 3), crd4(400));
    wait_out(cyc);
    exp_v = mk(0, 1, 401, 32767, 50);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL mask_one_lane: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
    send(1, 1, 4'b0000, d4(1, 2, 3, 4), crd4(500));
    wait_out(cyc);
    exp_v = mk(1, 0, 0, 32767, 32767);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL mask_none: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_ratio();
    send(1, 1, 4'b1111, d4(80, 100, 200, 300), crd4(600));
    wait_out(cyc);
    exp_v = mk(0, 0, 600, 100, 80);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL ratio_equal: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
    send(1, 1, 4'b1111, d4(79, 100, 200, 300), crd4(700));
    wait_out(cyc);
    exp_v = mk(0, 1, 700, 100, 79);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL ratio_below: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_first_restart();
    send(1, 0, 4'b1111, d4(5, 6, 7, 8), crd4(800));
    send(1, 1, 4'b1111, d4(100, 200, 150, 300), crd4(900));
    wait_out(cyc);
    checks++;
    if (cyc !== 1) begin
      errors++;
      $display("FAIL restart_single_output: got %0d cycles to out_valid, want 1", cyc);
    end
    exp_v = mk(0, 1, 900, 150, 100);
    checks++;
    if (res !== exp_v) begin
      errors++;
      $display("FAIL restart_result: got res=%h, want res=%h", res, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [50:0] exp_a;
    out_ready = 1'b0;
    send(1, 1, 4'b1111, d4(10, 20, 30, 40), crd4(1200));
    send(1, 1, 4'b1111, d4(7, 9, 8, 100), crd4(1300));
    in_first = 1'b1; in_last = 1'b1; in_mask = 4'b1111;
    in_dist = d4(300, 200, 100, 90); in_coord = crd4(1400); in_valid = 1'b1;
    exp_a = mk(0, 1, 1200, 20, 10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, res} !== {1'b0, 1'b1, exp_a}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got rdy=%0b vld=%0b res=%h, want rdy=0 vld=1 res=%h",
                 i, in_ready, out_valid, res, exp_a);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    exp_v = mk(0, 0, 1300, 8, 7);
    checks++;
    if ({out_valid, res} !== {1'b1, exp_v}) begin
      errors++;
      $display("FAIL bp_second: got vld=%0b res=%h, want vld=1 res=%h", out_valid, res, exp_v);
    end
    @(negedge clk);
    exp_v = mk(0, 0, 1403, 100, 90);
    checks++;
    if ({out_valid, res} !== {1'b1, exp_v}) begin
      errors++;
      $display("FAIL bp_third: got vld=%0b res=%h, want vld=1 res=%h", out_valid, res, exp_v);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_sweep();
    send(1, 0, 4'b1111, d4(1, 2, 3, 4), crd4(1500));
    send(0, 1, 4'b1111, d4(5, 6, 7, 8), crd4(1600));
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale_%0d: got out_valid=%0b, want 0", i, out_valid);
      end
      @(negedge clk);
    end
    send(1, 1, 4'b1111, d4(10, 20, 30, 40), crd4(1700));
    wait_out(cyc);
    exp_v = mk(0, 1, 1700, 20, 10);
    checks++;
    if (cyc < 0 || res !== exp_v) begin
      errors++;
      $display("FAIL rst_new_sweep: got cyc=%0d res=%h, want res=%h", cyc, res, exp_v);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_no_first();
    test_tie_latency();
    test_sweep();
    test_mask();
    test_ratio();
    test_first_restart();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
